// File: rtl/mem_loader.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : mem_loader
//  Purpose  : Streams a host program into memory under CPU hold, then reads
//             it back and compares byte sums to flag a load error.
//  Revision : 1.0  initial release
// ============================================================================
module mem_loader #(
   parameter int A_WIDTH = 5,
   parameter int D_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [A_WIDTH-1:0] in_len,
   input  logic [D_WIDTH-1:0] in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [A_WIDTH-1:0] mem_addr,
   output logic               mem_wr,
   output logic               mem_rd,
   inout  wire  [D_WIDTH-1:0] mem_data,
   output logic               busy,
   output logic               cpu_hold,
   output logic               done,
   output logic               error,
   output logic [D_WIDTH-1:0] checksum
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_VERIFY = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [A_WIDTH-1:0] len_q,   len_d;
   logic [A_WIDTH-1:0] wptr_q,  wptr_d;
   logic [A_WIDTH:0]   k_q,     k_d;
   logic [D_WIDTH-1:0] wsum_q,  wsum_d;
   logic [D_WIDTH-1:0] rsum_q,  rsum_d;
   logic               error_q, error_d;
   logic [A_WIDTH:0]   n_bytes;

   // One bit wider than the address so that a full-depth load (N = 2^A_WIDTH)
   // can still be counted through the extra trailing verify cycle.
   assign n_bytes  = {1'b0, len_q} + 1'b1;

   assign busy     = (state_q != S_IDLE);
   assign cpu_hold = busy;
   assign checksum = wsum_q;
   assign mem_data = mem_wr ? in_data : {D_WIDTH{1'bz}};

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      wptr_d   = wptr_q;
      k_d      = k_q;
      wsum_d   = wsum_q;
      rsum_d   = rsum_q;
      error_d  = error_q;
      in_ready = 1'b0;
      mem_wr   = 1'b0;
      mem_rd   = 1'b0;
      mem_addr = '0;
      done     = 1'b0;
      error    = error_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d   = in_len;
               wptr_d  = '0;
               k_d     = '0;
               wsum_d  = '0;
               rsum_d  = '0;
               error_d = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            mem_addr = wptr_q;
            if (in_valid) begin
               mem_wr = 1'b1;
               wsum_d = wsum_q + in_data;
               if (wptr_q == len_q) begin
                  state_d = S_VERIFY;
               end else begin
                  wptr_d = wptr_q + 1'b1;
               end
            end
         end
         S_VERIFY: begin
            k_d = k_q + 1'b1;
            // Read data lags its address by one cycle, so cycle k sums byte k-1.
            if (k_q != '0) begin
               rsum_d = rsum_q + mem_data;
            end
            if (k_q < n_bytes) begin
               mem_rd   = 1'b1;
               mem_addr = k_q[A_WIDTH-1:0];
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            error   = (rsum_q != wsum_q);
            error_d = error;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         wptr_q  <= '0;
         k_q     <= '0;
         wsum_q  <= '0;
         rsum_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wptr_q  <= wptr_d;
         k_q     <= k_d;
         wsum_q  <= wsum_d;
         rsum_q  <= rsum_d;
         error_q <= error_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_loader
//  Purpose  : Self-checking bench for mem_loader with a one-cycle-latency
//             memory model that can emulate a stuck-at-0 data bit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [4:0] in_len;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] mem_addr;
   logic       mem_wr;
   logic       mem_rd;
   wire  [7:0] mem_data;
   logic       busy;
   logic       cpu_hold;
   logic       done;
   logic       error;
   logic [7:0] checksum;

   int errors = 0;
   int checks = 0;
   bit prev_err = 1'b0;
   bit stuck0 = 1'b0;

   logic [7:0] mem [0:31];
   logic [7:0] rd_q = 8'h00;
   logic       rd_vld = 1'b0;

   always #5 clk = ~clk;

   mem_loader #(.A_WIDTH(5), .D_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in_len(in_len), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .mem_addr(mem_addr),
      .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_data(mem_data), .busy(busy),
      .cpu_hold(cpu_hold), .done(done), .error(error), .checksum(checksum)
   );

   // Memory: writes land on the edge, read data is presented the next cycle.
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr] <= stuck0 ? (mem_data & 8'hFE) : mem_data;
      if (mem_rd) rd_q <= mem[mem_addr];
      rd_vld <= mem_rd;
   end
   assign mem_data = rd_vld ? rd_q : 8'hzz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: byte sum written vs byte sum a (possibly faulty) memory returns.
   function automatic logic [8:0] model(input logic [4:0] len, input logic [255:0] b,
                                        input bit stuck);
      logic [7:0] ws = 8'h00;
      logic [7:0] rs = 8'h00;
      for (int i = 0; i <= int'(len); i++) begin
         ws = ws + b[8*i +: 8];
         rs = rs + (stuck ? (b[8*i +: 8] & 8'hFE) : b[8*i +: 8]);
      end
      return {(ws != rs), ws};
   endfunction

   // Entered and left one time unit after a rising edge.
   task automatic run_seq(input logic [4:0] len, input logic [255:0] bytes,
                          input int gap_after, input int gap_len, input bit rnd_valid,
                          input bit glitch, output logic [7:0] got_cks,
                          output logic got_err, output int got_done);
      int n      = int'(len) + 1;
      int idx    = 0;
      int gapcnt = 0;
      int lastwr = -1;
      bit v;
      bit exp_rd;
      got_done = -1;
      got_cks  = 8'h00;
      got_err  = 1'b0;

      start = 1'b1; in_len = len; in_valid = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_err_held", 32'(error), 32'(prev_err));
      @(posedge clk); #1;

      for (int c = 1; c < 300; c++) begin
         start = 1'b0;
         if (glitch && c == 2) begin
            start  = 1'b1;
            in_len = len ^ 5'h10;
         end
         v = 1'b0;
         if (idx < n) begin
            if (gap_after == idx && gapcnt < gap_len) gapcnt++;
            else if (rnd_valid && $urandom_range(0, 3) == 0) v = 1'b0;
            else v = 1'b1;
         end
         in_valid = v;
         in_data  = v ? bytes[8*idx +: 8] : 8'($urandom);
         @(negedge clk);
         if (c == 1) chk("err_cleared", 32'(error), 32'd0);
         chk("busy", 32'(busy), 32'd1);
         chk("cpu_hold", 32'(cpu_hold), 32'd1);
         if (idx < n) chk("in_ready", 32'(in_ready), 32'd1);
         chk("mem_wr", 32'(mem_wr), 32'(v));
         if (v) begin
            chk("wr_addr", 32'(mem_addr), 32'(idx));
            chk("wr_data", 32'(mem_data), 32'(bytes[8*idx +: 8]));
         end
         exp_rd = (lastwr >= 0) && (c > lastwr) && (c <= lastwr + n);
         chk("mem_rd", 32'(mem_rd), 32'(exp_rd));
         if (exp_rd) chk("rd_addr", 32'(mem_addr), 32'(c - lastwr - 1));
         chk("done", 32'(done), 32'((lastwr >= 0) && (c == lastwr + n + 2)));
         if (done) begin
            got_done = c;
            got_cks  = checksum;
            got_err  = error;
         end
         if (v) begin
            idx++;
            if (idx == n) lastwr = c;
         end
         @(posedge clk); #1;
         if (lastwr >= 0 && c == lastwr + n + 2) break;
      end
      if (got_done < 0) chk("done_timeout", 32'd0, 32'd1);

      in_valid = 1'b0;
      @(negedge clk);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_hold", 32'(cpu_hold), 32'd0);
      chk("post_done", 32'(done), 32'd0);
      chk("err_sticky", 32'(error), 32'(got_err));
      prev_err = got_err;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [4:0]   len;
      logic [255:0] bytes;
      int           gap_after;
      int           gap_len;
      bit           stuck;
      bit           glitch;
      logic [7:0]   exp_cks;
      bit           exp_err;
      int           exp_done;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]   g_cks;
      logic         g_err;
      int           g_done;
      logic [255:0] rb;
      logic [4:0]   rl;
      logic [8:0]   m;

      vecs[0] = '{5'd3,  256'h44332211,  -1, 0, 1'b0, 1'b0, 8'hAA, 1'b0, 10};
      vecs[1] = '{5'd3,  256'h44332211,   2, 2, 1'b0, 1'b0, 8'hAA, 1'b0, 12};
      vecs[2] = '{5'd31, {32{8'hFF}},    -1, 0, 1'b0, 1'b0, 8'hE0, 1'b0, 66};
      vecs[3] = '{5'd1,  256'h0301,      -1, 0, 1'b1, 1'b0, 8'h04, 1'b1, 6};
      vecs[4] = '{5'd3,  256'h44332211,  -1, 0, 1'b0, 1'b1, 8'hAA, 1'b0, 10};

      rst = 1'b1; start = 1'b0; in_len = '0; in_data = '0; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hold", 32'(cpu_hold), 32'd0);
      chk("rst_wr", 32'(mem_wr), 32'd0);
      chk("rst_rd", 32'(mem_rd), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_cks", 32'(checksum), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(error), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 5; i++) begin
         stuck0 = vecs[i].stuck;
         run_seq(vecs[i].len, vecs[i].bytes, vecs[i].gap_after, vecs[i].gap_len,
                 1'b0, vecs[i].glitch, g_cks, g_err, g_done);
         chk($sformatf("vec%0d_cks", i), 32'(g_cks), 32'(vecs[i].exp_cks));
         chk($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_done_cyc", i), 32'(g_done), 32'(vecs[i].exp_done));
      end
      stuck0 = 1'b0;

      // Asynchronous reset in the middle of a LOAD cycle.
      start = 1'b1; in_len = 5'd7; in_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'h50 + 8'(i);
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_hold", 32'(cpu_hold), 32'd0);
      chk("arst_wr", 32'(mem_wr), 32'd0);
      chk("arst_ready", 32'(in_ready), 32'd0);
      chk("arst_addr", 32'(mem_addr), 32'd0);
      chk("arst_cks", 32'(checksum), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_err", 32'(error), 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      prev_err = 1'b0;
      @(posedge clk); #1;
      run_seq(vecs[0].len, vecs[0].bytes, -1, 0, 1'b0, 1'b0, g_cks, g_err, g_done);
      chk("reload_cks", 32'(g_cks), 32'hAA);
      chk("reload_err", 32'(g_err), 32'd0);
      chk("reload_done_cyc", 32'(g_done), 32'd10);

      for (int r = 0; r < 8; r++) begin
         rl = 5'($urandom_range(0, 31));
         for (int i = 0; i < 32; i++) rb[8*i +: 8] = 8'($urandom);
         stuck0 = ($urandom_range(0, 3) == 0);
         m = model(rl, rb, stuck0);
         run_seq(rl, rb, -1, 0, 1'b1, 1'b0, g_cks, g_err, g_done);
         chk($sformatf("rnd%0d_cks", r), 32'(g_cks), 32'(m[7:0]));
         chk($sformatf("rnd%0d_err", r), 32'(g_err), 32'(m[8]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameters SHALL be: A_WIDTH, default 5, memory address width; D_WIDTH, default 8, memory data width.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  begin a load/verify sequence; sampled only in IDLE.
REQ-005 in_len  input  A_WIDTH  byte count minus one (0 means 1 byte, 31 means 32 bytes); latched when start is accepted.
REQ-006 in_data  input  D_WIDTH  program byte from the host stream.
REQ-007 in_valid  input  1  in_data valid.
REQ-008 in_ready  output  1  loader accepts in_data this cycle.
REQ-009 mem_addr  output  A_WIDTH  memory address.
REQ-010 mem_wr  output  1  memory write strobe.
REQ-011 mem_rd  output  1  memory read strobe.
REQ-012 mem_data  inout  D_WIDTH  shared memory data bus.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 cpu_hold  output  1  holds the CPU off the memory bus while loading.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 error  output  1  readback checksum mismatch; sticky until the next accepted start.
REQ-017 checksum  output  D_WIDTH  modulo-2^D_WIDTH sum of the bytes written.

Function
REQ-018 The FSM SHALL have the states IDLE, LOAD, VERIFY and DONE.
REQ-019 IDLE: mem_wr=0, mem_rd=0, mem_data=Z, in_ready=0; start=1 latches in_len, clears the pointers, both sums and error, and moves to LOAD on the next edge.
REQ-020 LOAD: in_ready=1; an accept is in_valid&in_ready, and on an accept mem_wr=1 combinationally, mem_addr=wptr, and mem_data is driven with in_data in the same cycle.
REQ-021 mem_data SHALL be driven only while mem_wr=1 and SHALL be Z in every other cycle.
REQ-022 On each accept, wptr SHALL increment and wsum SHALL be updated to wsum+in_data; gaps in in_valid SHALL stall without a write or a pointer change.
REQ-023 The accept with wptr==latched len SHALL move the FSM to VERIFY; no write SHALL occur beyond that address.
REQ-024 VERIFY SHALL last N+1 cycles, with N=len+1 and cycles indexed k=0..N.
REQ-025 In VERIFY cycle k<N: mem_rd=1 and mem_addr=k.
REQ-026 In VERIFY cycle k=N: mem_rd=0.
REQ-027 In VERIFY cycles k=1..N, the loader SHALL add mem_data to rsum, because memory read data appears one cycle after the address.
REQ-028 After VERIFY cycle N, the FSM SHALL enter DONE.
REQ-029 DONE SHALL last 1 cycle: done=1, error is set to (rsum != wsum), checksum=wsum, and the FSM then returns to IDLE.
REQ-030 cpu_hold SHALL be high from the first LOAD cycle through the DONE cycle inclusive.
REQ-031 start SHALL be ignored while busy.
REQ-032 mem_wr and mem_rd SHALL never be high in the same cycle.
REQ-033 No write SHALL follow a read without an intervening cycle where both strobes are 0; the LOAD-then-VERIFY ordering guarantees this.
REQ-034 Timing with continuous in_valid and start accepted at the cycle-0 edge: LOAD occupies cycles 1..N, VERIFY occupies N+1..2N+1, and done pulses in cycle 2N+2.
REQ-035 Address arithmetic SHALL be A_WIDTH bits; len=31 SHALL reach address 31 and stop, with no wrap.
REQ-036 Sum arithmetic SHALL be D_WIDTH-bit wrap-around.

Reset
REQ-037 rst=1 SHALL immediately, without a clock, force IDLE; busy, cpu_hold, done, error, in_ready, mem_wr and mem_rd all 0; mem_addr=0; checksum=0; mem_data=Z.
REQ-038 Reset mid-LOAD or mid-VERIFY SHALL abandon the sequence; the next start SHALL begin again at address 0 with cleared sums.

Verification
REQ-039 Async reset asserted mid-cycle during LOAD -> outputs are zero and the bus is Z before the next edge; after release, start re-loads from address 0.
REQ-040 len=3, bytes 11,22,33,44 hex, continuous valid -> mem_wr in cycles 1-4 at addresses 0-3; mem_rd in cycles 5-8; done in cycle 10; checksum AA hex; error 0.
REQ-041 Same bytes with in_valid low for 2 cycles after the second byte -> no write during the gap; addresses stay contiguous; done in cycle 12; checksum AA hex.
REQ-042 len=31, all bytes FF hex -> last write to address 31; checksum E0 hex; error 0; done in cycle 66.
REQ-043 Memory model with data bit 0 stuck at 0, len=1, bytes 01,03 hex -> error=1 in the DONE cycle and held until the next start.
REQ-044 start pulsed during LOAD -> ignored, with no restart and no latching of a new in_len.
